// File: rtl/cotm32_pipeline_pkg.sv
// Shared pipeline types: fetch queue entry layout, NOP encoding and a
// saturating counter helper used by the prefetcher.
package cotm32_pipeline_pkg;

  localparam int XLEN       = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [INST_WIDTH-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  access_fault;
    logic                  addr_misaligned;
  } fetch_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order sync FIFO of fetch entries with flush; push while full is
// accepted only when a pop frees the slot in the same cycle.
module fetch_fifo
  import cotm32_pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; the pointers decide what is visible.
  always_ff @(posedge i_clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_prefetch_buf.sv
// Decoupled instruction prefetcher: credit-limited sequential fetch into an
// in-order queue, with redirect flush. Optional counters: INST_PREFETCH_STATS_EN.
module inst_prefetch_buf
  import cotm32_pipeline_pkg::*;
#(
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR    = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_redirect,
  input  logic [XLEN-1:0]       i_redirect_addr,
  output logic                  o_mem_req,
  output logic [XLEN-1:0]       o_mem_addr,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [INST_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_err,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [XLEN-1:0]       o_pc,
  output logic [XLEN-1:0]       o_pc_4,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic                  o_access_fault,
  output logic                  o_addr_misaligned,
  output logic [31:0]           o_stat_empty,
  output logic [31:0]           o_stat_redirects
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0]   count;
  logic [OW-1:0]   outstanding, drop_cnt, out_nxt;
  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic            halted, started, mis_pend;
  logic            mem_grant, rsp_take, redir_mis;
  logic            push, pop, empty;
  fetch_entry_t    push_data, head;

  // Credit covers queued plus in-flight entries, so responses never overflow.
  assign o_mem_req = started && !halted && !i_redirect
                  && ((int'(count) + int'(outstanding)) < DEPTH)
                  && (int'(outstanding) < MAX_OUTSTANDING);
  assign o_mem_addr = fetch_pc;
  assign mem_grant  = o_mem_req && i_mem_gnt;
  assign rsp_take   = i_mem_rvalid && (drop_cnt == '0);
  assign redir_mis  = |i_redirect_addr[1:0];
  assign out_nxt    = outstanding + OW'(mem_grant) - OW'(i_mem_rvalid);

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (!i_redirect) begin
      if (mis_pend) begin
        push                      = 1'b1;
        push_data.pc              = resp_pc;
        push_data.inst            = INST_NOP;
        push_data.addr_misaligned = 1'b1;
      end else if (rsp_take) begin
        push                      = 1'b1;
        push_data.pc              = resp_pc;
        push_data.inst            = i_mem_rdata;
        push_data.access_fault    = i_mem_err;
        push_data.addr_misaligned = |resp_pc[1:0];
      end
    end
  end

  assign pop = o_valid && i_ready && !i_redirect;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      started     <= 1'b0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_pc    <= RESET_VECTOR;
      resp_pc     <= RESET_VECTOR;
      halted      <= 1'b0;
      mis_pend    <= 1'b0;
    end else begin
      started     <= 1'b1;
      outstanding <= out_nxt;
      if (i_redirect) begin
        // Everything still in flight after this edge predates the redirect.
        drop_cnt <= out_nxt;
        fetch_pc <= i_redirect_addr;
        resp_pc  <= i_redirect_addr;
        halted   <= redir_mis;
        mis_pend <= redir_mis;
      end else begin
        if (mem_grant) fetch_pc <= fetch_pc + XLEN'(4);
        if (i_mem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (push) resp_pc <= resp_pc + XLEN'(4);
        if (mis_pend) mis_pend <= 1'b0;
        if (rsp_take && i_mem_err) halted <= 1'b1;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (i_redirect),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  assign o_valid           = !empty;
  assign o_pc              = head.pc;
  assign o_pc_4            = head.pc + XLEN'(4);
  assign o_access_fault    = o_valid && head.access_fault;
  assign o_addr_misaligned = o_valid && head.addr_misaligned;
  assign o_inst            = (head.access_fault || head.addr_misaligned) ? INST_NOP : head.inst;

`ifdef INST_PREFETCH_STATS_EN
  logic [31:0] stat_empty_q, stat_redir_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stat_empty_q <= '0;
      stat_redir_q <= '0;
    end else begin
      if (!o_valid && i_ready) stat_empty_q <= sat_inc32(stat_empty_q);
      if (i_redirect)          stat_redir_q <= sat_inc32(stat_redir_q);
    end
  end

  assign o_stat_empty     = stat_empty_q;
  assign o_stat_redirects = stat_redir_q;
`else
  assign o_stat_empty     = '0;
  assign o_stat_redirects = '0;
`endif

endmodule
